mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-master arbiter between the instruction-fetch and load/store stages and the single-port unified memory. It accepts one request at a time over valid/ready, issues it to the memory as a one-cycle enable pulse, and waits a parameterised number of cycles. It then returns the read data, or a write acknowledge, to the requesting master as a one-cycle response pulse. Only one transaction is in flight at any time.

## Interface
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width; `DATA_W/8` mask bits.
- `LATENCY`, 1, cycles from the `mem_en` cycle until `mem_rdata` is valid; legal range 1..15.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-low.
- `ifu_req_valid` in 1: fetch request.
- `ifu_req_ready` out 1: fetch request accepted this cycle when high together with valid.
- `ifu_req_addr` in ADDR_W: fetch address.
- `ifu_resp_valid` out 1: one-cycle fetch response.
- `ifu_resp_data` out DATA_W: fetched word.
- `lsu_req_valid` in 1: load/store request.
- `lsu_req_ready` out 1: load/store request accepted.
- `lsu_req_addr` in ADDR_W: load/store address.
- `lsu_req_wen` in 1: 1 = store, 0 = load.
- `lsu_req_wdata` in DATA_W: store data.
- `lsu_req_wmask` in DATA_W/8: byte-lane write mask.
- `lsu_resp_valid` out 1: one-cycle load data or store acknowledge.
- `lsu_resp_data` out DATA_W: load data; 0 for store acknowledge.
- `mem_en` out 1: memory access strobe.
- `mem_wen` out 1: memory write.
- `mem_addr` out ADDR_W: memory address.
- `mem_wdata` out DATA_W: memory write data.
- `mem_wmask` out DATA_W/8: memory write mask.
- `mem_rdata` in DATA_W: memory read data.
- `busy` out 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset state is IDLE.
- IDLE:
  - The granted master's `*_req_ready` is driven combinationally to 1; the other master's ready is 0.
  - Default grant is fixed priority: LSU over IFU.
  - A grant is made only if the corresponding valid is high.
  - On valid && ready the block latches master id, addr, wen, wdata and wmask, then goes to ISSUE.
  - IFU requests are always latched as reads with wmask 0.
- ISSUE (one cycle):
  - `mem_en` = 1. `mem_wen`, `mem_addr`, `mem_wdata` and `mem_wmask` come from the latched request.
  - The latency counter is loaded with LATENCY-1.
  - Next state is WAIT, or RESP if LATENCY = 1 and the data has been captured (see Timing).
- WAIT: the counter decrements each cycle. In the cycle it reads 0, `mem_rdata` is captured into the response register, and the next state is RESP.
- RESP (one cycle):
  - The latched master's `*_resp_valid` = 1 and its `*_resp_data` = the captured word (0 for stores).
  - Next state is IDLE.
- Both `*_req_ready` are 0 in ISSUE, WAIT and RESP.
- A master may hold valid across busy cycles; it is not accepted until IDLE.
- Responses carry no ready signal; masters must always sink them.
- `mem_*` outputs are registered. Outside the ISSUE cycle they hold 0.
- `*_resp_data` holds its last value after the pulse; it is 0 after reset.
- A store with wmask = 0 is still issued (`mem_en` = 1, `mem_wen` = 1, `mem_wmask` = 0) and still acknowledged.

## Timing
- Accept in cycle T. `mem_en` is high in T+1. `mem_rdata` is valid in cycle T+1+LATENCY and sampled at the end of that cycle. `resp_valid` is high in T+2+LATENCY.
- The next accept is possible at T+3+LATENCY at the earliest. With LATENCY=1: response at T+3, next accept at T+4.
- Both valids high in IDLE: exactly one is granted, per the arbitration policy. The loser's ready is 0, and its request remains pending.
- Reset values (rst = 0 at a clock edge):
  - FSM returns to IDLE.
  - All ready, resp_valid and `mem_*` outputs are 0, resp_data is 0, `busy` is 0.
  - Any in-flight transaction is dropped with no response and no further `mem_en`.
- While rst is low, both readies are forced to 0.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin arbitration.
  - A 1-bit last-grant register is reset to "IFU", so the first contended grant goes to LSU.
  - On contention, the master not granted last wins.
  - Uncontended requests are granted immediately regardless of the pointer.
  - The pointer updates only on accept.
- `MEM_ARB_RR_EN` undefined: fixed LSU-over-IFU priority, and the pointer logic is absent.

## Test plan
- Reset, then single IFU read at addr 0x8000_0000 with LATENCY=1 and memory returning 0x0010_0093 -> `mem_en` at T+1 with `mem_addr`=0x8000_0000, `ifu_resp_valid` at T+3 with data 0x0010_0093, `busy` low at T+4.
- LSU store with addr 0x8000_0100, wdata 0xDEAD_BEEF, wmask 4'b0001 -> in ISSUE, `mem_wen`=1, `mem_wmask`=0001, `mem_wdata`=0xDEAD_BEEF; `lsu_resp_valid` at T+3 with data 0; IFU resp stays 0.
- IFU and LSU valid in the same IDLE cycle, three back-to-back rounds:
  - Without the macro: grants are LSU, LSU, LSU.
  - With `MEM_ARB_RR_EN`: grants are LSU, IFU, LSU.
- LATENCY=4, LSU load -> `mem_en` at T+1, `lsu_resp_valid` exactly at T+6, both readies 0 from T+1 to T+6.
- Drive rst=0 during WAIT of an IFU read -> next cycle all outputs are 0, no `ifu_resp_valid` ever appears for that request, and a new request after rst=1 completes normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-master (IFU/LSU) arbiter onto a single-port memory with a fixed access latency.
// Define MEM_ARB_RR_EN for round-robin arbitration; the default build uses fixed LSU-over-IFU priority.
module mem_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned LATENCY = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_req_addr,
  output logic                ifu_resp_valid,
  output logic [DATA_W-1:0]   ifu_resp_data,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_req_addr,
  input  logic                lsu_req_wen,
  input  logic [DATA_W-1:0]   lsu_req_wdata,
  input  logic [DATA_W/8-1:0] lsu_req_wmask,
  output logic                lsu_resp_valid,
  output logic [DATA_W-1:0]   lsu_resp_data,
  output logic                mem_en,
  output logic                mem_wen,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  localparam int unsigned MASK_W = DATA_W / 8;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                lsu_sel_q;
  logic                wen_q;
  logic                mem_en_q;
  logic                mem_wen_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [MASK_W-1:0]   mem_wmask_q;
  logic                ifu_resp_valid_q;
  logic                lsu_resp_valid_q;
  logic [DATA_W-1:0]   ifu_resp_data_q;
  logic [DATA_W-1:0]   lsu_resp_data_q;
  logic                busy_q;

  logic contend;
  logic grant_lsu;
  logic grant_ifu;
  logic can_accept;

  assign contend = ifu_req_valid && lsu_req_valid;

`ifdef MEM_ARB_RR_EN
  // Last-grant pointer: 1 = LSU was granted last; resets to IFU so LSU wins first contention
  logic last_lsu_q;

  assign grant_lsu = lsu_req_valid && (!contend || !last_lsu_q);

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_lsu_q <= 1'b0;
    end else if (lsu_req_ready) begin
      last_lsu_q <= 1'b1;
    end else if (ifu_req_ready) begin
      last_lsu_q <= 1'b0;
    end
  end
`else
  assign grant_lsu = lsu_req_valid;
`endif

  assign grant_ifu     = ifu_req_valid && !grant_lsu;
  assign can_accept    = rst && (state_q == IDLE);
  assign lsu_req_ready = can_accept && grant_lsu;
  assign ifu_req_ready = can_accept && grant_ifu;

  // Transaction FSM; mem_* are single-cycle pulses set on accept and cleared by default
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      lsu_sel_q        <= 1'b0;
      wen_q            <= 1'b0;
      mem_en_q         <= 1'b0;
      mem_wen_q        <= 1'b0;
      mem_addr_q       <= '0;
      mem_wdata_q      <= '0;
      mem_wmask_q      <= '0;
      ifu_resp_valid_q <= 1'b0;
      lsu_resp_valid_q <= 1'b0;
      ifu_resp_data_q  <= '0;
      lsu_resp_data_q  <= '0;
      busy_q           <= 1'b0;
    end else begin
      mem_en_q         <= 1'b0;
      mem_wen_q        <= 1'b0;
      mem_addr_q       <= '0;
      mem_wdata_q      <= '0;
      mem_wmask_q      <= '0;
      ifu_resp_valid_q <= 1'b0;
      lsu_resp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (lsu_req_ready) begin
            mem_en_q    <= 1'b1;
            mem_wen_q   <= lsu_req_wen;
            mem_addr_q  <= lsu_req_addr;
            mem_wdata_q <= lsu_req_wdata;
            mem_wmask_q <= lsu_req_wmask;
            lsu_sel_q   <= 1'b1;
            wen_q       <= lsu_req_wen;
            state_q     <= ISSUE;
            busy_q      <= 1'b1;
          end else if (ifu_req_ready) begin
            mem_en_q    <= 1'b1;
            mem_addr_q  <= ifu_req_addr;
            lsu_sel_q   <= 1'b0;
            wen_q       <= 1'b0;
            state_q     <= ISSUE;
            busy_q      <= 1'b1;
          end
        end
        ISSUE: begin
          cnt_q   <= CNT_W'(LATENCY - 1);
          state_q <= WAIT;
        end
        WAIT: begin
          if (cnt_q == '0) begin
            state_q <= RESP;
            if (lsu_sel_q) begin
              lsu_resp_valid_q <= 1'b1;
              lsu_resp_data_q  <= wen_q ? '0 : mem_rdata;
            end else begin
              ifu_resp_valid_q <= 1'b1;
              ifu_resp_data_q  <= mem_rdata;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        RESP: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_en         = mem_en_q;
  assign mem_wen        = mem_wen_q;
  assign mem_addr       = mem_addr_q;
  assign mem_wdata      = mem_wdata_q;
  assign mem_wmask      = mem_wmask_q;
  assign ifu_resp_valid = ifu_resp_valid_q;
  assign lsu_resp_valid = lsu_resp_valid_q;
  assign ifu_resp_data  = ifu_resp_data_q;
  assign lsu_resp_data  = lsu_resp_data_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance at LATENCY=1, one at LATENCY=4.
// Grant expectations follow MEM_ARB_RR_EN when it is defined.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;

  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
  logic [31:0] ifu_req_addr, ifu_resp_data;
  logic        lsu_req_valid, lsu_req_ready, lsu_req_wen, lsu_resp_valid;
  logic [31:0] lsu_req_addr, lsu_req_wdata, lsu_resp_data;
  logic [3:0]  lsu_req_wmask, mem_wmask;
  logic        mem_en, mem_wen, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic        d4_ifu_req_valid, d4_ifu_req_ready, d4_ifu_resp_valid;
  logic [31:0] d4_ifu_req_addr, d4_ifu_resp_data;
  logic        d4_lsu_req_valid, d4_lsu_req_ready, d4_lsu_req_wen, d4_lsu_resp_valid;
  logic [31:0] d4_lsu_req_addr, d4_lsu_req_wdata, d4_lsu_resp_data;
  logic [3:0]  d4_lsu_req_wmask, d4_mem_wmask;
  logic        d4_mem_en, d4_mem_wen, d4_busy;
  logic [31:0] d4_mem_addr, d4_mem_wdata, d4_mem_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(1)) u_dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_data(ifu_resp_data),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
    .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_data(lsu_resp_data),
    .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .ifu_req_valid(d4_ifu_req_valid), .ifu_req_ready(d4_ifu_req_ready), .ifu_req_addr(d4_ifu_req_addr),
    .ifu_resp_valid(d4_ifu_resp_valid), .ifu_resp_data(d4_ifu_resp_data),
    .lsu_req_valid(d4_lsu_req_valid), .lsu_req_ready(d4_lsu_req_ready), .lsu_req_addr(d4_lsu_req_addr),
    .lsu_req_wen(d4_lsu_req_wen), .lsu_req_wdata(d4_lsu_req_wdata), .lsu_req_wmask(d4_lsu_req_wmask),
    .lsu_resp_valid(d4_lsu_resp_valid), .lsu_resp_data(d4_lsu_resp_data),
    .mem_en(d4_mem_en), .mem_wen(d4_mem_wen), .mem_addr(d4_mem_addr), .mem_wdata(d4_mem_wdata),
    .mem_wmask(d4_mem_wmask), .mem_rdata(d4_mem_rdata), .busy(d4_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Land 1 time unit after the active edge; drive and sample from there
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    logic exp_lsu;
    rst = 1'b0;
    ifu_req_valid = 1'b0; ifu_req_addr = '0;
    lsu_req_valid = 1'b0; lsu_req_addr = '0; lsu_req_wen = 1'b0;
    lsu_req_wdata = '0; lsu_req_wmask = '0; mem_rdata = '0;
    d4_ifu_req_valid = 1'b0; d4_ifu_req_addr = '0;
    d4_lsu_req_valid = 1'b0; d4_lsu_req_addr = '0; d4_lsu_req_wen = 1'b0;
    d4_lsu_req_wdata = '0; d4_lsu_req_wmask = '0; d4_mem_rdata = '0;

    // Reset: readies stay low even with valid asserted
    ifu_req_valid = 1'b1;
    d4_lsu_req_valid = 1'b1;
    step(); step(); settle();
    chk("rst_ifu_ready", 32'(ifu_req_ready), 32'd0);
    chk("rst_d4_lsu_ready", 32'(d4_lsu_req_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_ifu_resp_valid", 32'(ifu_resp_valid), 32'd0);
    chk("rst_ifu_resp_data", ifu_resp_data, 32'd0);
    chk("rst_lsu_resp_data", lsu_resp_data, 32'd0);
    ifu_req_valid = 1'b0;
    d4_lsu_req_valid = 1'b0;
    rst = 1'b1;
    step();

    // Single IFU read, LATENCY=1
    mem_rdata = 32'h0010_0093;
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0000;
    settle();
    chk("t1_ifu_ready", 32'(ifu_req_ready), 32'd1);
    chk("t1_lsu_ready", 32'(lsu_req_ready), 32'd0);
    step(); ifu_req_valid = 1'b0; settle();
    chk("t1_mem_en", 32'(mem_en), 32'd1);
    chk("t1_mem_addr", mem_addr, 32'h8000_0000);
    chk("t1_mem_wen", 32'(mem_wen), 32'd0);
    chk("t1_mem_wmask", 32'(mem_wmask), 32'd0);
    chk("t1_busy", 32'(busy), 32'd1);
    step();
    chk("t1_mem_en_off", 32'(mem_en), 32'd0);
    chk("t1_resp_early", 32'(ifu_resp_valid), 32'd0);
    step();
    chk("t1_resp_valid", 32'(ifu_resp_valid), 32'd1);
    chk("t1_resp_data", ifu_resp_data, 32'h0010_0093);
    chk("t1_lsu_resp_valid", 32'(lsu_resp_valid), 32'd0);
    step();
    chk("t1_busy_low", 32'(busy), 32'd0);
    chk("t1_resp_pulse", 32'(ifu_resp_valid), 32'd0);
    chk("t1_resp_hold", ifu_resp_data, 32'h0010_0093);

    // LSU store with a single byte lane
    lsu_req_valid = 1'b1; lsu_req_wen = 1'b1; lsu_req_addr = 32'h8000_0100;
    lsu_req_wdata = 32'hDEAD_BEEF; lsu_req_wmask = 4'b0001;
    settle();
    chk("t2_lsu_ready", 32'(lsu_req_ready), 32'd1);
    chk("t2_ifu_ready", 32'(ifu_req_ready), 32'd0);
    step(); lsu_req_valid = 1'b0; settle();
    chk("t2_mem_en", 32'(mem_en), 32'd1);
    chk("t2_mem_wen", 32'(mem_wen), 32'd1);
    chk("t2_mem_addr", mem_addr, 32'h8000_0100);
    chk("t2_mem_wmask", 32'(mem_wmask), 32'd1);
    chk("t2_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    step(); step();
    chk("t2_lsu_resp_valid", 32'(lsu_resp_valid), 32'd1);
    chk("t2_lsu_resp_data", lsu_resp_data, 32'd0);
    chk("t2_ifu_resp_valid", 32'(ifu_resp_valid), 32'd0);
    chk("t2_ifu_resp_hold", ifu_resp_data, 32'h0010_0093);
    step();

    // Fresh reset so the round-robin pointer starts at IFU
    rst = 1'b0; step(); rst = 1'b1;

    // Three back-to-back contended rounds
    lsu_req_wen = 1'b0; lsu_req_wmask = 4'b0000; lsu_req_wdata = '0;
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h0000_1000;
    lsu_req_valid = 1'b1; lsu_req_addr = 32'h0000_2000;
    mem_rdata = 32'h0000_AAAA;
    for (int r = 0; r < 3; r++) begin
`ifdef MEM_ARB_RR_EN
      exp_lsu = (r != 1);
`else
      exp_lsu = 1'b1;
`endif
      settle();
      chk("t3_lsu_ready", 32'(lsu_req_ready), 32'(exp_lsu));
      chk("t3_ifu_ready", 32'(ifu_req_ready), 32'(!exp_lsu));
      step();
      chk("t3_mem_addr", mem_addr, exp_lsu ? 32'h0000_2000 : 32'h0000_1000);
      chk("t3_busy_readies", 32'({ifu_req_ready, lsu_req_ready}), 32'd0);
      step(); step();
      chk("t3_lsu_resp", 32'(lsu_resp_valid), 32'(exp_lsu));
      chk("t3_ifu_resp", 32'(ifu_resp_valid), 32'(!exp_lsu));
      step();
    end
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    step();

    // LATENCY=4 load with IFU also pending
    d4_mem_rdata = 32'hCAFE_F00D;
    d4_lsu_req_valid = 1'b1; d4_lsu_req_addr = 32'h0000_3000;
    d4_ifu_req_valid = 1'b1; d4_ifu_req_addr = 32'h0000_3100;
    settle();
    chk("t4_lsu_ready", 32'(d4_lsu_req_ready), 32'd1);
    chk("t4_ifu_ready", 32'(d4_ifu_req_ready), 32'd0);
    for (int k = 1; k <= 6; k++) begin
      step();
      chk("t4_mem_en", 32'(d4_mem_en), 32'(k == 1));
      chk("t4_lsu_resp_valid", 32'(d4_lsu_resp_valid), 32'(k == 6));
      chk("t4_ifu_resp_valid", 32'(d4_ifu_resp_valid), 32'd0);
      chk("t4_readies", 32'({d4_ifu_req_ready, d4_lsu_req_ready}), 32'd0);
      chk("t4_busy", 32'(d4_busy), 32'd1);
      if (k == 1) begin
        chk("t4_mem_addr", d4_mem_addr, 32'h0000_3000);
        chk("t4_mem_wen", 32'(d4_mem_wen), 32'd0);
        chk("t4_mem_wdata", d4_mem_wdata, 32'd0);
        chk("t4_mem_wmask", 32'(d4_mem_wmask), 32'd0);
      end
      if (k == 6) begin
        chk("t4_resp_data", d4_lsu_resp_data, 32'hCAFE_F00D);
        d4_lsu_req_valid = 1'b0;
        d4_ifu_req_valid = 1'b0;
      end
    end
    step();
    chk("t4_busy_low", 32'(d4_busy), 32'd0);
    chk("t4_resp_pulse", 32'(d4_lsu_resp_valid), 32'd0);
    chk("t4_ifu_resp_data", d4_ifu_resp_data, 32'd0);

    // Reset during WAIT drops the in-flight IFU read
    mem_rdata = 32'h0BAD_0BAD;
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h0000_4000;
    settle();
    chk("t5_ifu_ready", 32'(ifu_req_ready), 32'd1);
    step(); ifu_req_valid = 1'b0; settle();
    chk("t5_mem_en", 32'(mem_en), 32'd1);
    step();
    chk("t5_wait_busy", 32'(busy), 32'd1);
    chk("t5_wait_resp", 32'(ifu_resp_valid), 32'd0);
    rst = 1'b0;
    step();
    ifu_req_valid = 1'b1;
    settle();
    chk("t5_rst_ifu_ready", 32'(ifu_req_ready), 32'd0);
    chk("t5_rst_resp_valid", 32'(ifu_resp_valid), 32'd0);
    chk("t5_rst_ifu_data", ifu_resp_data, 32'd0);
    chk("t5_rst_lsu_data", lsu_resp_data, 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_mem_en", 32'(mem_en), 32'd0);
    chk("t5_rst_mem_addr", mem_addr, 32'd0);
    ifu_req_valid = 1'b0;
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t5_no_resp", 32'(ifu_resp_valid), 32'd0);
      chk("t5_no_mem_en", 32'(mem_en), 32'd0);
    end
    mem_rdata = 32'h1111_2222;
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h0000_5000;
    settle();
    chk("t5_new_ready", 32'(ifu_req_ready), 32'd1);
    step(); ifu_req_valid = 1'b0; settle();
    chk("t5_new_mem_addr", mem_addr, 32'h0000_5000);
    step(); step();
    chk("t5_new_resp_valid", 32'(ifu_resp_valid), 32'd1);
    chk("t5_new_resp_data", ifu_resp_data, 32'h1111_2222);
    step();
    chk("t5_new_busy_low", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
